// File: rtl/zx_kbd_pkg.sv
// Shared types, scan-code constants and lookup helpers for the PS/2 to ZX Spectrum keyboard bridge.
`timescale 1ns/1ps
package zx_kbd_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    typedef logic [7:0][4:0] matrix_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    localparam int FILTER_CYCLES = 8;

    localparam logic [7:0] SC_RELEASE = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_PAUSE   = 8'hE1;
    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CTRL    = 8'h14;
    localparam logic [7:0] SC_ALT     = 8'h11;
    localparam logic [7:0] SC_UP      = 8'h75;
    localparam logic [7:0] SC_DOWN    = 8'h72;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_RIGHT   = 8'h74;
    localparam logic [7:0] SC_BKSP    = 8'h66;

    function automatic key_pos_t kp(input int r, input int c);
        return {1'b1, 3'(r), 3'(c)};
    endfunction

    // Set-2 scan code to Spectrum half-row position; column 0 is the outermost key of each half-row.
    function automatic key_pos_t key_map(input logic [7:0] code);
        key_pos_t k;
        k = '0;
        case (code)
            SC_LSHIFT: k = kp(0, 0);  8'h1A: k = kp(0, 1);  8'h22: k = kp(0, 2);
            8'h21:     k = kp(0, 3);  8'h2A: k = kp(0, 4);
            8'h1C:     k = kp(1, 0);  8'h1B: k = kp(1, 1);  8'h23: k = kp(1, 2);
            8'h2B:     k = kp(1, 3);  8'h34: k = kp(1, 4);
            8'h15:     k = kp(2, 0);  8'h1D: k = kp(2, 1);  8'h24: k = kp(2, 2);
            8'h2D:     k = kp(2, 3);  8'h2C: k = kp(2, 4);
            8'h16:     k = kp(3, 0);  8'h1E: k = kp(3, 1);  8'h26: k = kp(3, 2);
            8'h25:     k = kp(3, 3);  8'h2E: k = kp(3, 4);
            8'h45:     k = kp(4, 0);  8'h46: k = kp(4, 1);  8'h3E: k = kp(4, 2);
            8'h3D:     k = kp(4, 3);  8'h36: k = kp(4, 4);
            8'h4D:     k = kp(5, 0);  8'h44: k = kp(5, 1);  8'h43: k = kp(5, 2);
            8'h3C:     k = kp(5, 3);  8'h35: k = kp(5, 4);
            8'h5A:     k = kp(6, 0);  8'h4B: k = kp(6, 1);  8'h42: k = kp(6, 2);
            8'h3B:     k = kp(6, 3);  8'h33: k = kp(6, 4);
            8'h29:     k = kp(7, 0);  SC_RSHIFT: k = kp(7, 1);  8'h3A: k = kp(7, 2);
            8'h31:     k = kp(7, 3);  8'h32: k = kp(7, 4);
            default:   k = '0;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] fn_index(input logic [7:0] code);
        case (code)
            8'h05: return 4'd1;   8'h06: return 4'd2;   8'h04: return 4'd3;
            8'h0C: return 4'd4;   8'h03: return 4'd5;   8'h0B: return 4'd6;
            8'h83: return 4'd7;   8'h0A: return 4'd8;   8'h01: return 4'd9;
            8'h09: return 4'd10;  8'h78: return 4'd11;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, clock glitch filter, framing FSM and 1 ms frame timeout.
`timescale 1ns/1ps
module ps2_rx
    import zx_kbd_pkg::*;
#(
    parameter int CLK_HZ = 28000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_error
);

    localparam int TIMEOUT = CLK_HZ / 1000;
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int FW      = $clog2(FILTER_CYCLES);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic [FW-1:0] stable_q;
    logic          clk_filt_q;
    rx_state_t     state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_ok_q;
    logic [TW-1:0] idle_cnt_q;
    logic          clk_s, data_s, fall;

    assign clk_s   = clk_sync_q[1];
    assign data_s  = data_sync_q[1];
    assign rx_byte = shift_q;

    // A new level is only believed after it has differed from the filtered level for FILTER_CYCLES clocks.
    assign fall = (clk_s != clk_filt_q) && (stable_q == FW'(FILTER_CYCLES - 1)) && !clk_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            stable_q    <= '0;
            clk_filt_q  <= 1'b1;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_ok_q <= 1'b0;
            idle_cnt_q  <= '0;
            rx_valid    <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            rx_valid    <= 1'b0;
            rx_error    <= 1'b0;

            if (clk_s == clk_filt_q) begin
                stable_q <= '0;
            end else if (stable_q == FW'(FILTER_CYCLES - 1)) begin
                stable_q   <= '0;
                clk_filt_q <= clk_s;
            end else begin
                stable_q <= stable_q + FW'(1);
            end

            if (state_q == RX_IDLE || fall) idle_cnt_q <= '0;
            else                            idle_cnt_q <= idle_cnt_q + TW'(1);

            if (state_q != RX_IDLE && !fall && idle_cnt_q == TW'(TIMEOUT - 1)) begin
                state_q <= RX_IDLE;
            end else if (fall) begin
                case (state_q)
                    RX_IDLE: begin
                        if (!data_s) state_q <= RX_DATA;
                        bit_cnt_q <= '0;
                    end
                    RX_DATA: begin
                        shift_q   <= {data_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        parity_ok_q <= ^{shift_q, data_s};
                        state_q     <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (parity_ok_q && data_s) rx_valid <= 1'b1;
                        else                       rx_error <= 1'b1;
                        state_q <= RX_IDLE;
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 keyboard to ZX Spectrum 8x5 key matrix with F-key and modifier levels.
// Define PS2_KBD_CURSOR_EN to map the arrow keys and backspace onto CS+digit combinations.
`timescale 1ns/1ps
module ps2_keyboard_matrix
    import zx_kbd_pkg::*;
#(
    parameter int CLK_HZ = 28000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [7:0]  addr,
    output logic [4:0]  key_data,
    output logic [11:1] Fn,
    output logic [2:0]  mod,
    output logic        rx_error
);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    matrix_t     matrix_q, matrix_d, overlay;
    logic [11:1] fn_q, fn_d;
    logic [1:0]  ctrl_q, ctrl_d, alt_q, alt_d;
    logic        release_q, release_d, ext_q, ext_d;
    logic [2:0]  skip_q, skip_d;
    logic        prefix_byte, apply, press;
    key_pos_t    key_pos;
    logic [3:0]  fn_idx;
    logic [4:0]  sel;

    ps2_rx #(.CLK_HZ(CLK_HZ)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_error (rx_error)
    );

    assign prefix_byte = rx_byte inside {SC_RELEASE, SC_EXT, SC_PAUSE};
    assign apply       = rx_valid && (skip_q == 3'd0) && !prefix_byte;
    assign press       = !release_q;
    assign key_pos     = key_map(rx_byte);
    assign fn_idx      = fn_index(rx_byte);

    // Only Ctrl, Alt and the cursor keys honour the E0 prefix; other extended codes are ignored.
    always_comb begin
        matrix_d  = matrix_q;
        fn_d      = fn_q;
        ctrl_d    = ctrl_q;
        alt_d     = alt_q;
        release_d = release_q;
        ext_d     = ext_q;
        skip_d    = skip_q;
        if (rx_valid) begin
            if (skip_q != 3'd0)            skip_d    = skip_q - 3'd1;
            else if (rx_byte == SC_PAUSE)   skip_d    = 3'd7;
            else if (rx_byte == SC_RELEASE) release_d = 1'b1;
            else if (rx_byte == SC_EXT)     ext_d     = 1'b1;
        end
        if (apply) begin
            release_d = 1'b0;
            ext_d     = 1'b0;
            if (!ext_q && key_pos.hit)  matrix_d[key_pos.row][key_pos.col] = press;
            if (!ext_q && fn_idx != '0) fn_d[fn_idx] = press;
            if (rx_byte == SC_CTRL)     ctrl_d[ext_q] = press;
            if (rx_byte == SC_ALT)      alt_d[ext_q]  = press;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matrix_q  <= '0;
            fn_q      <= '0;
            ctrl_q    <= '0;
            alt_q     <= '0;
            release_q <= 1'b0;
            ext_q     <= 1'b0;
            skip_q    <= '0;
        end else begin
            matrix_q  <= matrix_d;
            fn_q      <= fn_d;
            ctrl_q    <= ctrl_d;
            alt_q     <= alt_d;
            release_q <= release_d;
            ext_q     <= ext_d;
            skip_q    <= skip_d;
        end
    end

`ifdef PS2_KBD_CURSOR_EN
    // Bits: 0 up, 1 down, 2 left, 3 right, 4 backspace. Kept apart so releasing one never drops a Shift-held CS.
    logic [4:0] cursor_q, cursor_d;

    always_comb begin
        cursor_d = cursor_q;
        if (apply) begin
            if (ext_q) begin
                case (rx_byte)
                    SC_UP:    cursor_d[0] = press;
                    SC_DOWN:  cursor_d[1] = press;
                    SC_LEFT:  cursor_d[2] = press;
                    SC_RIGHT: cursor_d[3] = press;
                    default:  ;
                endcase
            end else if (rx_byte == SC_BKSP) begin
                cursor_d[4] = press;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cursor_q <= '0;
        else       cursor_q <= cursor_d;
    end

    always_comb begin
        overlay       = '0;
        overlay[0][0] = |cursor_q;
        overlay[4][3] = cursor_q[0];
        overlay[4][4] = cursor_q[1];
        overlay[3][4] = cursor_q[2];
        overlay[4][2] = cursor_q[3];
        overlay[4][0] = cursor_q[4];
    end
`else
    assign overlay = '0;
`endif

    always_comb begin
        sel = '0;
        for (int r = 0; r < 8; r++) begin
            if (!addr[r]) sel = sel | matrix_q[r] | overlay[r];
        end
        key_data = ~sel;
    end

    assign Fn  = fn_q;
    assign mod = {matrix_q[0][0] | matrix_q[7][1], |alt_q, |ctrl_q};

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Directed self-checking bench: drives PS/2 frames bit by bit and compares outputs with hand-computed values.
`timescale 1ns/1ps
module tb_ps2_keyboard_matrix;

    localparam int CLK_HZ = 1_000_000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [7:0]  addr;
    logic [4:0]  key_data;
    logic [11:1] Fn;
    logic [2:0]  mod;
    logic        rx_error;

    int checks     = 0;
    int failures   = 0;
    int err_pulses = 0;
    int err_before = 0;

    ps2_keyboard_matrix #(.CLK_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .addr     (addr),
        .key_data (key_data),
        .Fn       (Fn),
        .mod      (mod),
        .rx_error (rx_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_error === 1'b1) err_pulses++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkKeys(input string tag, input logic [7:0] a, input logic [4:0] expected);
        addr = a;
        #1;
        checkOutput(tag, {27'd0, key_data}, {27'd0, expected});
    endtask

    // One PS/2 bit cell: data set while the clock is high, 20-cycle low phase, back high.
    task automatic ps2Bit(input logic b);
        ps2_data = b;
        #100;
        ps2_clk = 1'b0;
        #200;
        ps2_clk = 1'b1;
        #100;
    endtask

    task automatic applyStimulus(input logic [7:0] code, input logic bad_parity, input logic bad_stop);
        ps2Bit(1'b0);
        for (int i = 0; i < 8; i++) ps2Bit(code[i]);
        ps2Bit(~(^code) ^ bad_parity);
        ps2Bit(~bad_stop);
        ps2_data = 1'b1;
        #400;
    endtask

    task automatic sendByte(input logic [7:0] code);
        applyStimulus(code, 1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        addr     = 8'hFF;
        #23;
        reset = 1'b0;
        #20;

        $display("[TB] reset values");
        checkKeys("reset_keys_all_rows", 8'h00, 5'h1F);
        checkOutput("reset_fn", {21'd0, Fn}, 32'h0);
        checkOutput("reset_mod", {29'd0, mod}, 32'h0);
        checkOutput("reset_rx_error", {31'd0, rx_error}, 32'h0);

        $display("[TB] press and release A");
        sendByte(8'h1C);
        checkKeys("a_press_row1", 8'hFD, 5'b11110);
        checkKeys("a_press_addr_ff", 8'hFF, 5'h1F);
        checkKeys("a_press_other_row", 8'hFE, 5'h1F);
        sendByte(8'hF0);
        sendByte(8'h1C);
        checkKeys("a_release", 8'hFD, 5'h1F);

        $display("[TB] bad parity and bad stop bit");
        err_before = err_pulses;
        applyStimulus(8'h1C, 1'b1, 1'b0);
        checkOutput("parity_err_pulse", err_pulses - err_before, 1);
        checkKeys("parity_err_no_key", 8'hFD, 5'h1F);
        err_before = err_pulses;
        applyStimulus(8'h1A, 1'b0, 1'b1);
        checkOutput("stop_err_pulse", err_pulses - err_before, 1);
        checkKeys("stop_err_no_key", 8'h00, 5'h1F);

        $display("[TB] stalled frame then recovery");
        err_before = err_pulses;
        ps2Bit(1'b0);
        ps2Bit(1'b0);
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        ps2Bit(1'b1);
        ps2_data = 1'b1;
        #12000;
        sendByte(8'h1C);
        checkKeys("stall_recover_a", 8'hFD, 5'b11110);
        checkOutput("stall_no_error", err_pulses - err_before, 0);
        sendByte(8'hF0);
        sendByte(8'h1C);

        $display("[TB] typematic repeat");
        sendByte(8'h1C);
        sendByte(8'h1C);
        checkKeys("typematic_held", 8'hFD, 5'b11110);
        sendByte(8'hF0);
        sendByte(8'h1C);
        checkKeys("typematic_release", 8'hFD, 5'h1F);

        $display("[TB] Ctrl + F11, right Alt");
        sendByte(8'h14);
        sendByte(8'h78);
        checkOutput("f11_level", {21'd0, Fn}, 32'h400);
        checkOutput("ctrl_mod", {29'd0, mod}, 32'h1);
        sendByte(8'hE0);
        sendByte(8'h11);
        checkOutput("ralt_mod", {29'd0, mod}, 32'h3);
        sendByte(8'hF0);
        sendByte(8'h78);
        checkOutput("f11_release", {21'd0, Fn}, 32'h0);
        sendByte(8'hF0);
        sendByte(8'h14);
        checkOutput("ctrl_release", {29'd0, mod}, 32'h2);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h11);
        checkOutput("ralt_release", {29'd0, mod}, 32'h0);

        $display("[TB] rows 0 and 7 together");
        sendByte(8'h1A);
        sendByte(8'h3A);
        checkKeys("z_m_all_rows", 8'h00, 5'b11001);
        checkKeys("z_row0", 8'hFE, 5'b11101);
        checkKeys("m_row7", 8'h7F, 5'b11011);
        sendByte(8'hF0);
        sendByte(8'h1A);
        sendByte(8'hF0);
        sendByte(8'h3A);
        checkKeys("z_m_released", 8'h00, 5'h1F);

        $display("[TB] shifts");
        sendByte(8'h12);
        checkKeys("lshift_cs", 8'hFE, 5'b11110);
        checkOutput("lshift_mod", {29'd0, mod}, 32'h4);
        sendByte(8'h59);
        checkKeys("rshift_ss", 8'h7F, 5'b11101);
        sendByte(8'hF0);
        sendByte(8'h12);
        sendByte(8'hF0);
        sendByte(8'h59);
        checkOutput("shift_release_mod", {29'd0, mod}, 32'h0);

        $display("[TB] Pause sequence skipped");
        sendByte(8'hE1);
        sendByte(8'h14);
        sendByte(8'h77);
        sendByte(8'hE1);
        sendByte(8'hF0);
        sendByte(8'h14);
        sendByte(8'hF0);
        sendByte(8'h77);
        checkOutput("pause_mod", {29'd0, mod}, 32'h0);
        checkKeys("pause_keys", 8'h00, 5'h1F);
        sendByte(8'h1A);
        checkKeys("after_pause_z", 8'hFE, 5'b11101);
        sendByte(8'hF0);
        sendByte(8'h1A);

`ifdef PS2_KBD_CURSOR_EN
        $display("[TB] cursor keys");
        sendByte(8'hE0);
        sendByte(8'h75);
        checkKeys("up_cs", 8'hFE, 5'b11110);
        checkKeys("up_7", 8'hEF, 5'b10111);
        sendByte(8'h12);
        sendByte(8'hF0);
        sendByte(8'h12);
        checkKeys("up_keeps_cs", 8'hFE, 5'b11110);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        checkKeys("up_released", 8'h00, 5'h1F);
        sendByte(8'h66);
        checkKeys("bksp_0", 8'hEF, 5'b11110);
        sendByte(8'hF0);
        sendByte(8'h66);
        checkKeys("bksp_released", 8'h00, 5'h1F);
`else
        $display("[TB] cursor codes unmapped");
        sendByte(8'h66);
        checkKeys("bksp_unmapped", 8'h00, 5'h1F);
        sendByte(8'hE0);
        sendByte(8'h75);
        checkKeys("up_unmapped", 8'h00, 5'h1F);
        sendByte(8'hF0);
        sendByte(8'h66);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
`endif

        $display("[TB] reset mid-frame");
        sendByte(8'h14);
        sendByte(8'h05);
        sendByte(8'h1C);
        checkKeys("pre_reset_a", 8'hFD, 5'b11110);
        checkOutput("pre_reset_fn", {21'd0, Fn}, 32'h1);
        checkOutput("pre_reset_mod", {29'd0, mod}, 32'h1);
        err_before = err_pulses;
        ps2Bit(1'b0);
        ps2Bit(1'b0);
        ps2Bit(1'b1);
        reset = 1'b1;
        #30;
        reset = 1'b0;
        #20;
        checkKeys("midreset_keys", 8'h00, 5'h1F);
        checkOutput("midreset_fn", {21'd0, Fn}, 32'h0);
        checkOutput("midreset_mod", {29'd0, mod}, 32'h0);
        checkOutput("midreset_rx_error", {31'd0, rx_error}, 32'h0);
        sendByte(8'h1C);
        checkKeys("post_reset_a", 8'hFD, 5'b11110);
        checkOutput("post_reset_no_error", err_pulses - err_before, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_matrix.md
PS2_KEYBOARD_MATRIX -- requirements
Module: ps2_keyboard_matrix

Interface
REQ-001 SHALL have parameter CLK_HZ, default 28000000, system clock frequency used to derive the frame timeout.
REQ-002 SHALL have port clk, input, 1, system clock (clk_sys domain).
REQ-003 SHALL have port reset, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port ps2_clk, input, 1, PS/2 keyboard clock (12-16 kHz, asynchronous to clk).
REQ-005 SHALL have port ps2_data, input, 1, PS/2 keyboard data.
REQ-006 SHALL have port addr, input, 8, CPU address bits [15:8]; each 0 bit selects one half-row.
REQ-007 SHALL have port key_data, output, 5, ULA keyboard column bits, active-low.
REQ-008 SHALL have port Fn, output, 11 (bits [11:1]), level of F1..F11 while held.
REQ-009 SHALL have port mod, output, 3, modifier levels: [0]=any Ctrl, [1]=any Alt, [2]=any Shift.
REQ-010 SHALL have port rx_error, output, 1, one-clk pulse on a discarded frame.

Function
REQ-011 SHALL synchronise ps2_clk and ps2_data through 2 flip-flops each.
REQ-012 SHALL accept a falling edge of ps2_clk only after the synchronised level has been stable for 8 clk cycles.
REQ-013 SHALL run the receiver FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, sampling ps2_data on each accepted falling edge.
REQ-014 SHALL stay in IDLE when the start bit samples as 1.
REQ-015 SHALL discard the byte and pulse rx_error on odd-parity failure or when the stop bit is 0.
REQ-016 SHALL abort to IDLE without a byte when no accepted edge occurs for CLK_HZ/1000 cycles while outside IDLE (1 ms).
REQ-017 SHALL deliver a valid byte to the decoder one clk after the STOP sample.
REQ-018 SHALL set a release flag on byte 0xF0 and an extended flag on 0xE0.
REQ-019 SHALL apply the next non-prefix byte as press or release according to the release flag, then clear both flags.
REQ-020 SHALL discard the 7 bytes following 0xE1 (Pause) without changing state.
REQ-021 SHALL ignore unmapped codes apart from clearing the flags.
REQ-022 SHALL hold an 8x5 pressed matrix using standard Spectrum row order: row0 CS Z X C V, row1 A-G, row2 Q-T, row3 1-5, row4 0-6, row5 P-Y, row6 ENTER-H, row7 SPACE SS M N B.
REQ-023 SHALL map left Shift (0x12) to CS and right Shift (0x59) to SS.
REQ-024 SHALL set key_data[c] = NOT(OR over rows r with addr[r]==0 of matrix[r][c]), combinationally, with zero latency.
REQ-025 SHALL yield key_data = 5'h1F when addr = 8'hFF.
REQ-026 SHALL track Ctrl and Alt including E0 variants, and set mod and Fn as levels.
REQ-027 SHALL let a repeated make (typematic) re-set an already-set bit, with no effect.

Reset
REQ-028 SHALL, on reset, clear the matrix, cursor vector, Fn, mod, flags and skip counter, put the FSM in IDLE and drive rx_error to 0.
REQ-029 SHALL, on reset mid-frame, discard the partial frame.

Configuration
REQ-030 SHALL, with PS2_KBD_CURSOR_EN defined, keep a separate 5-bit cursor vector (E0 75 up=CS+7, E0 72 down=CS+6, E0 6B left=CS+5, E0 74 right=CS+8, 0x66 backspace=CS+0), ORed into the matrix at the output.
REQ-031 SHALL, with PS2_KBD_CURSOR_EN defined, ensure that releasing a cursor key never clears a CS held via Shift.
REQ-032 SHALL, without PS2_KBD_CURSOR_EN, treat those codes as unmapped.

Structure
REQ-033 SHALL place the receiver state enum, matrix typedef, scan-code constants and the 8-cycle filter constant in package zx_kbd_pkg.
REQ-034 SHALL implement the PS/2 frame receiver (REQ-011..REQ-017) as sub-module ps2_rx, with byte/valid/error outputs.

Verification
REQ-035 SHALL cover: frame 0x1C, addr=8'hFD -> key_data=5'b11110; then F0 1C -> 5'b11111.
REQ-036 SHALL cover: 0x1C with wrong parity -> rx_error pulses once; key_data stays 5'b11111.
REQ-037 SHALL cover (CURSOR_EN): E0 75 -> addr=8'hFE gives 5'b11110 and addr=8'hEF gives 5'b10111; F0 12 while up is held keeps CS.
REQ-038 SHALL cover: ps2_clk stalled after 4 data bits for 1 ms, then a full 0x1C frame -> 0x1C decoded correctly.
REQ-039 SHALL cover: reset asserted mid-frame with 'A' held -> all outputs at reset values; next frame decodes cleanly.
REQ-040 SHALL cover: 0x78 (F11) with 0x14 (Ctrl) held -> Fn[11]=1, mod=3'b001; addr=8'h00 with keys in rows 0 and 7 -> OR of both rows.
